sort_engine: RTL

Parametrised hardware sorter: the fixed-function successor to the 8-entry software sort program, generalised in element count, width, signedness and sort direction. It sorts N elements with an odd-even transposition network evaluated one phase per clock. It exits early once the data is ordered. It sits beside the processor core as a start/done offload block and optionally reports phase and swap statistics in place of an instruction count.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_cmp_swap.sv | 39 +++
 rtl/sort_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SORT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CNT_W = 32;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell; a disabled cell passes lo/hi straight through.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W      = 32,
  parameter bit SIGNED = 1
) (
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         desc,
  input  logic         en,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         swapped
);

  logic signed [W-1:0] lo_s;
  logic signed [W-1:0] hi_s;
  logic                gt;
  logic                lt;

  assign lo_s = lo;
  assign hi_s = hi;

  always_comb begin
    if (SIGNED) begin
      gt = lo_s > hi_s;
      lt = lo_s < hi_s;
    end else begin
      gt = lo > hi;
      lt = lo < hi;
    end
    // Strict compares keep equal elements in place.
    swapped = en & ((desc == DIR_DESC) ? lt : gt);
    lo_o    = swapped ? hi : lo;
    hi_o    = swapped ? lo : hi;
  end

endmodule

// File: rtl/sort_engine.sv
// Start/done odd-even transposition sorter, one phase per clock, early exit.
// Optional statistics counters are built when SORT_ENGINE_STATS_EN is defined.
module sort_engine
  import sort_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 32,
  parameter bit SIGNED = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             desc,
  input  logic [N*W-1:0]   a_in,
  output logic [N*W-1:0]   a_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] n_phase_out,
  output logic [CNT_W-1:0] n_swap_out
);

  localparam int PH_W = $clog2(N + 1);

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    work [N];
  logic [W-1:0]    nxt  [N];
  logic [W-1:0]    lo_o [N-1];
  logic [W-1:0]    hi_o [N-1];
  logic [N-2:0]    en;
  logic [N-2:0]    swp;
  logic            desc_q;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_inc;
  logic            prev_zero;
  logic            any_swap;
  logic            last_phase;

  for (genvar i = 0; i < N - 1; i++) begin : g_cell
    localparam bit PAR = (i % 2) == 1;
    assign en[i] = (ph[0] == PAR);
    sort_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cell (
      .lo      (work[i]),
      .hi      (work[i+1]),
      .desc    (desc_q),
      .en      (en[i]),
      .lo_o    (lo_o[i]),
      .hi_o    (hi_o[i]),
      .swapped (swp[i])
    );
  end

  // Enabled pairs never overlap, so each element comes from exactly one cell.
  always_comb begin
    nxt[0]   = lo_o[0];
    nxt[N-1] = hi_o[N-2];
    for (int j = 1; j < N - 1; j++) begin
      nxt[j] = en[j-1] ? hi_o[j-1] : lo_o[j];
    end
  end

  assign any_swap   = |swp;
  assign ph_inc     = ph + 1'b1;
  assign last_phase = (ph_inc == PH_W'(N)) ||
                      ((ph_inc >= PH_W'(2)) && !any_swap && prev_zero);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SORT;
      SORT:    if (last_phase) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage boundary: working array, phase tracking and the result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N; j++) work[j] <= '0;
      desc_q    <= DIR_ASC;
      ph        <= '0;
      prev_zero <= 1'b0;
      a_out     <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: if (start) begin
          for (int j = 0; j < N; j++) work[j] <= a_in[j*W +: W];
          desc_q    <= desc;
          ph        <= '0;
          prev_zero <= 1'b0;
        end
        SORT: begin
          for (int j = 0; j < N; j++) work[j] <= nxt[j];
          ph        <= ph_inc;
          prev_zero <= !any_swap;
        end
        FINISH: for (int j = 0; j < N; j++) a_out[j*W +: W] <= work[j];
        default: ;
      endcase
    end
  end

`ifdef SORT_ENGINE_STATS_EN
  logic [CNT_W-1:0] ph_cnt;
  logic [CNT_W-1:0] sw_cnt;
  logic [CNT_W-1:0] phase_swaps;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    phase_swaps = '0;
    for (int i = 0; i < N - 1; i++) phase_swaps = phase_swaps + CNT_W'(swp[i]);
  end

  // Stage boundary: statistics counters and their FINISH snapshot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_cnt      <= '0;
      sw_cnt      <= '0;
      n_phase_out <= '0;
      n_swap_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ph_cnt <= '0;
          sw_cnt <= '0;
        end
        SORT: begin
          ph_cnt <= sat_add(ph_cnt, CNT_W'(1));
          sw_cnt <= sat_add(sw_cnt, phase_swaps);
        end
        FINISH: begin
          n_phase_out <= ph_cnt;
          n_swap_out  <= sw_cnt;
        end
        default: ;
      endcase
    end
  end
`else
  assign n_phase_out = '0;
  assign n_swap_out  = '0;
`endif

endmodule
